// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, load/store op codes, FSM encoding and store formatting helpers
package mem_access_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int AluOpBus   = 8;
  localparam int StopBus    = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Half and word ops, used for alignment checking
  function automatic logic is_half_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
  endfunction

  function automatic logic is_word_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  // Byte-lane enables; loads use the same lanes as the matching store width
  function automatic logic [3:0] lane_sel(input logic [AluOpBus-1:0] op, input logic [1:0] addr_lo);
    logic [3:0] sel;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel = 4'b0001 << addr_lo;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:                          sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated across every lane so the slave picks whatever sel enables
  function automatic logic [RegBus-1:0] store_data(input logic [AluOpBus-1:0] op, input logic [RegBus-1:0] reg2);
    logic [RegBus-1:0] d;
    case (op)
      EXE_SB_OP: d = {4{reg2[7:0]}};
      EXE_SH_OP: d = {2{reg2[15:0]}};
      default:   d = reg2;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load lane select with sign/zero extension
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   rdata,
  output logic [RegBus-1:0]   data_out
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane; byte 0 sits at rdata[7:0] (little-endian)
  always_comb begin
    w_byte = 8'h00;
    case (addr_lo)
      2'b00:   w_byte = rdata[7:0];
      2'b01:   w_byte = rdata[15:8];
      2'b10:   w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane according to the load flavour
  always_comb begin
    data_out = rdata;
    case (aluop)
      EXE_LB_OP:  data_out = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: data_out = {24'h000000, w_byte};
      EXE_LH_OP:  data_out = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: data_out = {16'h0000, w_half};
      default:    data_out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MIPS MEM stage with req/ack data bus; optional MEM_ALIGN_CHECK_EN alignment exceptions
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  input  logic [RegBus-1:0]     mem_pc,
  input  logic [StopBus-1:0]    stall,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  stallreq,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [3:0]            dbus_sel,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [RegBus-1:0]     dbus_wdata,
  input  logic [RegBus-1:0]     dbus_rdata,
  input  logic                  dbus_ack
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  excp_adel,
  output logic                  excp_ades,
  output logic [RegBus-1:0]     badvaddr,
  output logic [RegBus-1:0]     excp_pc
`endif
);

  mem_state_t        r_state;
  mem_state_t        w_next_state;
  logic [RegBus-1:0] r_rdata_q;
  logic [RegBus-1:0] w_load_data;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_misaligned;
  logic              w_issue;

  assign w_is_load  = is_load_op(mem_aluop);
  assign w_is_store = is_store_op(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (is_half_op(mem_aluop) && mem_mem_addr[0]) ||
                        (is_word_op(mem_aluop) && (mem_mem_addr[1:0] != 2'b00));
`else
  // Without the check, unused low address bits are simply ignored
  logic w_unused_pc;
  assign w_misaligned = 1'b0;
  assign w_unused_pc  = ^mem_pc;
`endif

  logic w_unused_stall;
  assign w_unused_stall = ^{stall[5], stall[3:0]};

  // A bus access is live in IDLE/BUSY; DONE guarantees the access is never repeated
  assign w_issue = (w_is_load || w_is_store) && !w_misaligned && (r_state != ST_DONE);

  mem_load_align u_load_align (
    .aluop    (mem_aluop),
    .addr_lo  (mem_mem_addr[1:0]),
    .rdata    (dbus_rdata),
    .data_out (w_load_data)
  );

  // State register; an outstanding request is dropped on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Hold the formatted load data from the ack cycle for replay while the stage is frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata_q <= '0;
    end else if (w_issue && dbus_ack) begin
      r_rdata_q <= w_load_data;
    end
  end

  // Next-state: wait for ack, park in DONE if the stage is frozen on the ack edge
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_BUSY: begin
        if (w_issue) begin
          if (dbus_ack) begin
            w_next_state = (stall[4] == Stop) ? ST_DONE : ST_IDLE;
          end else begin
            w_next_state = ST_BUSY;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (stall[4] == NoStop) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: pass-through by default, bus fields while issuing, replayed data in DONE
  always_comb begin
    wb_wd      = mem_wd;
    wb_wreg    = mem_wreg;
    wb_wdata   = mem_wdata;
    stallreq   = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_sel   = 4'b0000;
    dbus_addr  = '0;
    dbus_wdata = '0;
`ifdef MEM_ALIGN_CHECK_EN
    excp_adel  = 1'b0;
    excp_ades  = 1'b0;
    badvaddr   = '0;
    excp_pc    = '0;
`endif
    if (!rst) begin
      wb_wd    = '0;
      wb_wreg  = 1'b0;
      wb_wdata = '0;
    end else if (r_state == ST_DONE) begin
      if (w_is_load) begin
        wb_wdata = r_rdata_q;
      end
    end else if (w_issue) begin
      dbus_req   = 1'b1;
      dbus_we    = w_is_store;
      dbus_sel   = lane_sel(mem_aluop, mem_mem_addr[1:0]);
      dbus_addr  = {mem_mem_addr[31:2], 2'b00};
      dbus_wdata = store_data(mem_aluop, mem_reg2);
      stallreq   = !dbus_ack;
      if (w_is_load) begin
        wb_wdata = w_load_data;
      end
    end
`ifdef MEM_ALIGN_CHECK_EN
    else if (w_misaligned) begin
      wb_wreg   = 1'b0;
      excp_adel = w_is_load;
      excp_ades = w_is_store;
      badvaddr  = mem_mem_addr;
      excp_pc   = mem_pc;
    end
`endif
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access; MEM_ALIGN_CHECK_EN adds alignment checks
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_pc;
  logic [5:0]  stall;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
`ifdef MEM_ALIGN_CHECK_EN
  logic        excp_adel;
  logic        excp_ades;
  logic [31:0] badvaddr;
  logic [31:0] excp_pc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_stall_cycles;
  int n_xfers;
  logic [31:0] held_addr;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_pc       (mem_pc),
    .stall        (stall),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stallreq     (stallreq),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_sel     (dbus_sel),
    .dbus_addr    (dbus_addr),
    .dbus_wdata   (dbus_wdata),
    .dbus_rdata   (dbus_rdata),
    .dbus_ack     (dbus_ack)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .excp_adel    (excp_adel),
    .excp_ades    (excp_ades),
    .badvaddr     (badvaddr),
    .excp_pc      (excp_pc)
`endif
  );

  // Count completed bus transfers and stall-request cycles at each active edge
  always @(posedge clk) begin
    if (rst && dbus_req && dbus_ack) n_xfers <= n_xfers + 1;
    if (rst && stallreq) n_stall_cycles <= n_stall_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input logic ack);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    dbus_rdata   = rdata;
    dbus_ack     = ack;
    mem_wreg     = !is_store_op(op);
    mem_wd       = 5'd9;
    mem_wdata    = 32'h5555_AAAA;
    mem_pc       = 32'h0040_0010;
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'b000000;
    n_xfers = 0;
    n_stall_cycles = 0;
    set_op(EXE_LW_OP, 32'h100, 32'h0, 32'h1234_5678, 1'b0);
    #2;
    chk("rst_dbus_req", {31'b0, dbus_req}, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'h0);
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_wb_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("rst_wb_wd", {27'b0, wb_wd}, 32'h0);
    tick();
    rst = 1'b1;

    // Non-memory op passes through
    mem_aluop = 8'h21; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h1111_2222; dbus_ack = 1'b0;
    #1;
    chk("pass_wdata", wb_wdata, 32'h1111_2222);
    chk("pass_wd", {27'b0, wb_wd}, 32'd7);
    chk("pass_wreg", {31'b0, wb_wreg}, 32'd1);
    chk("pass_req", {31'b0, dbus_req}, 32'h0);
    chk("pass_stallreq", {31'b0, stallreq}, 32'h0);
    tick();

    // Zero-wait LW
    n_stall_cycles = 0;
    set_op(EXE_LW_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1);
    #1;
    chk("lw_wdata", wb_wdata, 32'hDEAD_BEEF);
    chk("lw_req", {31'b0, dbus_req}, 32'h1);
    chk("lw_we", {31'b0, dbus_we}, 32'h0);
    chk("lw_sel", {28'b0, dbus_sel}, 32'hF);
    chk("lw_addr", dbus_addr, 32'h100);
    chk("lw_stallreq", {31'b0, stallreq}, 32'h0);
    tick();
    chk("lw_no_stall_cycles", n_stall_cycles, 32'd0);

    // Byte and half loads with sign/zero extension
    set_op(EXE_LB_OP, 32'h103, 32'h0, 32'h8012_3456, 1'b1);
    #1;
    chk("lb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_sel", {28'b0, dbus_sel}, 32'h8);
    chk("lb_addr", dbus_addr, 32'h100);
    tick();
    set_op(EXE_LBU_OP, 32'h103, 32'h0, 32'h8012_3456, 1'b1);
    #1;
    chk("lbu_wdata", wb_wdata, 32'h0000_0080);
    tick();
    set_op(EXE_LB_OP, 32'h101, 32'h0, 32'h8012_3456, 1'b1);
    #1;
    chk("lb1_wdata", wb_wdata, 32'h0000_0034);
    tick();
    set_op(EXE_LH_OP, 32'h102, 32'h0, 32'h8012_3456, 1'b1);
    #1;
    chk("lh_wdata", wb_wdata, 32'hFFFF_8012);
    tick();
    set_op(EXE_LHU_OP, 32'h100, 32'h0, 32'h8012_8765, 1'b1);
    #1;
    chk("lhu_wdata", wb_wdata, 32'h0000_8765);
    chk("lhu_sel", {28'b0, dbus_sel}, 32'h3);
    tick();

    // Stores
    set_op(EXE_SH_OP, 32'h202, 32'h1234_ABCD, 32'h0, 1'b1);
    #1;
    chk("sh_sel", {28'b0, dbus_sel}, 32'hC);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dbus_addr, 32'h200);
    chk("sh_we", {31'b0, dbus_we}, 32'h1);
    chk("sh_wreg", {31'b0, wb_wreg}, 32'h0);
    tick();
    set_op(EXE_SB_OP, 32'h201, 32'h0000_00A5, 32'h0, 1'b1);
    #1;
    chk("sb_sel", {28'b0, dbus_sel}, 32'h2);
    chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
    tick();
    set_op(EXE_SW_OP, 32'h204, 32'h0BAD_F00D, 32'h0, 1'b1);
    #1;
    chk("sw_sel", {28'b0, dbus_sel}, 32'hF);
    chk("sw_wdata", dbus_wdata, 32'h0BAD_F00D);
    tick();

    // LW with three wait cycles, then stall[4] raised on the ack edge
    n_stall_cycles = 0;
    n_xfers = 0;
    set_op(EXE_LW_OP, 32'h300, 32'h0, 32'h0, 1'b0);
    #1;
    held_addr = dbus_addr;
    chk("dly_addr", held_addr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      chk("dly_req_held", {31'b0, dbus_req}, 32'h1);
      chk("dly_addr_stable", dbus_addr, 32'h300);
      chk("dly_stallreq", {31'b0, stallreq}, 32'h1);
      tick();
    end
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D; stall = 6'b110000;
    #1;
    chk("dly_ack_wdata", wb_wdata, 32'hCAFE_F00D);
    chk("dly_ack_stallreq", {31'b0, stallreq}, 32'h0);
    tick();
    chk("dly_stall_cycles", n_stall_cycles, 32'd3);
    dbus_ack = 1'b0; dbus_rdata = 32'h0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("done_req", {31'b0, dbus_req}, 32'h0);
      chk("done_stallreq", {31'b0, stallreq}, 32'h0);
      chk("done_wdata", wb_wdata, 32'hCAFE_F00D);
      tick();
    end
    stall = 6'b000000;
    #1;
    chk("done_release_req", {31'b0, dbus_req}, 32'h0);
    chk("done_release_wdata", wb_wdata, 32'hCAFE_F00D);
    tick();
    chk("dly_one_xfer", n_xfers, 32'd1);

    // Back-to-back op issues right after DONE
    set_op(EXE_LW_OP, 32'h304, 32'h0, 32'h0246_8ACE, 1'b1);
    #1;
    chk("b2b_req", {31'b0, dbus_req}, 32'h1);
    chk("b2b_wdata", wb_wdata, 32'h0246_8ACE);
    tick();

    // Reset while BUSY drops the request immediately
    set_op(EXE_LW_OP, 32'h400, 32'h0, 32'h0, 1'b0);
    tick();
    chk("busy_req", {31'b0, dbus_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("busy_rst_req", {31'b0, dbus_req}, 32'h0);
    chk("busy_rst_stallreq", {31'b0, stallreq}, 32'h0);
    tick();
    rst = 1'b1;
    set_op(EXE_LW_OP, 32'h500, 32'h0, 32'h1357_9BDF, 1'b1);
    #1;
    chk("post_rst_req", {31'b0, dbus_req}, 32'h1);
    chk("post_rst_addr", dbus_addr, 32'h500);
    chk("post_rst_wdata", wb_wdata, 32'h1357_9BDF);
    chk("post_rst_stallreq", {31'b0, stallreq}, 32'h0);
    tick();

    // Misaligned word access
    set_op(EXE_LW_OP, 32'h101, 32'h0, 32'h7777_8888, 1'b1);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("adel_flag", {31'b0, excp_adel}, 32'h1);
    chk("adel_badvaddr", badvaddr, 32'h101);
    chk("adel_pc", excp_pc, 32'h0040_0010);
    chk("adel_req", {31'b0, dbus_req}, 32'h0);
    chk("adel_wreg", {31'b0, wb_wreg}, 32'h0);
    tick();
    set_op(EXE_SH_OP, 32'h203, 32'h0, 32'h0, 1'b1);
    #1;
    chk("ades_flag", {31'b0, excp_ades}, 32'h1);
    chk("ades_req", {31'b0, dbus_req}, 32'h0);
`else
    chk("unalign_addr", dbus_addr, 32'h100);
    chk("unalign_sel", {28'b0, dbus_sel}, 32'hF);
    chk("unalign_wdata", wb_wdata, 32'h7777_8888);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
